// File: rtl/inner_product_seq.sv
// rtl/inner_product_seq.sv - sequential float32 inner product over one shared multiplier and adder core
module fp_core #(
    parameter bit IS_ADD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    // Normal operands only: denormals flush to zero, round to nearest even, no NaN handling.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e_in,
                                         input logic [23:0] m, input logic g, input logic st);
        logic [24:0]       mr;
        logic signed [9:0] e;
        e  = e_in;
        mr = {1'b0, m} + {24'd0, g & (st | m[0])};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end
        if (e >= 10'sd255) return {s, 8'hFF, 23'd0};
        if (e <= 10'sd0) return {s, 31'd0};
        return {s, e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic [47:0]       p;
        logic signed [9:0] e;
        logic              s;
        s = x[31] ^ y[31];
        if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
        e = $signed({2'b0, x[30:23]}) + $signed({2'b0, y[30:23]}) - 10'sd127;
        if (p[47]) return pack(s, e + 10'sd1, p[47:24], p[23], |p[22:0]);
        return pack(s, e, p[46:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0]       a;
        logic [31:0]       b;
        logic [26:0]       ma;
        logic [26:0]       mb;
        logic [26:0]       mask;
        logic [27:0]       sum;
        logic [7:0]        d8;
        logic [4:0]        d;
        logic signed [9:0] e;
        if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'd0};
        if (x[30:23] == 8'd0) return y;
        if (y[30:23] == 8'd0) return x;
        if (x[30:0] >= y[30:0]) begin
            a = x;
            b = y;
        end else begin
            a = y;
            b = x;
        end
        d8   = a[30:23] - b[30:23];
        d    = (d8 > 8'd26) ? 5'd27 : d8[4:0];
        ma   = {1'b1, a[22:0], 3'd0};
        mb   = {1'b1, b[22:0], 3'd0};
        mask = (27'd1 << d) - 27'd1;
        mb   = (mb >> d) | {26'd0, |(mb & mask)};
        e    = $signed({2'b0, a[30:23]});
        if (a[31] == b[31]) sum = {1'b0, ma} + {1'b0, mb};
        else sum = {1'b0, ma} - {1'b0, mb};
        if (sum == 28'd0) return 32'd0;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'sd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!sum[26]) begin
                    sum = sum << 1;
                    e   = e - 10'sd1;
                end
            end
        end
        return pack(a[31], e, sum[26:3], sum[2], |sum[1:0]);
    endfunction

    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        a_got;
    logic        b_got;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            a_got        <= 1'b0;
            b_got        <= 1'b0;
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z     <= 32'd0;
            output_z_stb <= 1'b0;
        end else begin
            input_a_ack <= input_a_stb & ~input_a_ack & ~a_got & ~output_z_stb;
            input_b_ack <= input_b_stb & ~input_b_ack & ~b_got & ~output_z_stb;
            if (input_a_stb & input_a_ack) begin
                a_q   <= input_a;
                a_got <= 1'b1;
            end
            if (input_b_stb & input_b_ack) begin
                b_q   <= input_b;
                b_got <= 1'b1;
            end
            if (a_got & b_got) begin
                output_z     <= IS_ADD ? fadd(a_q, b_q) : fmul(a_q, b_q);
                output_z_stb <= 1'b1;
                a_got        <= 1'b0;
                b_got        <= 1'b0;
            end else if (output_z_stb & output_z_ack) begin
                output_z_stb <= 1'b0;
            end
        end
    end
endmodule

module inner_product_seq #(
    parameter int N     = 4,
    parameter int LEN_W = $clog2(N + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [32*N-1:0] row,
    input  logic [32*N-1:0] column,
    input  logic [LEN_W-1:0] len,
    input  logic            acc_mode,
    input  logic            row_i_stb,
    input  logic            column_i_stb,
    output logic            row_i_ack,
    output logic            column_i_ack,
    output logic [31:0]     out,
    output logic            out_o_stb,
    input  logic            out_o_ack,
    output logic            busy
);
    typedef enum logic [2:0] {IDLE, MUL_REQ, MUL_WAIT, ADD_REQ, ADD_WAIT, DONE} state_t;
    state_t state_q, state_d;

    logic [32*N-1:0] row_q, col_q;
    logic [LEN_W-1:0] len_q, idx, len_c;
    logic [31:0] acc, prod, acc_init, mul_a, mul_b, mul_z, add_z;
    logic mul_a_stb, mul_b_stb, mul_a_ack, mul_b_ack, mul_z_stb, mul_z_ack;
    logic add_a_stb, add_b_stb, add_a_ack, add_b_ack, add_z_stb, add_z_ack;
    logic accept, last;

    assign len_c    = (len > LEN_W'(N)) ? LEN_W'(N) : len;
    assign acc_init = acc_mode ? out : 32'd0;
    assign accept   = (state_q == IDLE) & row_i_stb & column_i_stb;
    assign last     = !((idx + LEN_W'(1)) < len_q);
    assign busy     = (state_q != IDLE);

    always_comb begin
        mul_a = 32'd0;
        mul_b = 32'd0;
        for (int k = 0; k < N; k++) begin
            if (LEN_W'(k) == idx) begin
                mul_a = row_q[32*k +: 32];
                mul_b = col_q[32*k +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = (len_c == '0) ? DONE : MUL_REQ;
            MUL_REQ:  if ((~mul_a_stb | mul_a_ack) & (~mul_b_stb | mul_b_ack)) state_d = MUL_WAIT;
            MUL_WAIT: if (mul_z_stb) state_d = ADD_REQ;
            ADD_REQ:  if ((~add_a_stb | add_a_ack) & (~add_b_stb | add_b_ack)) state_d = ADD_WAIT;
            ADD_WAIT: if (add_z_stb) state_d = last ? DONE : MUL_REQ;
            DONE:     if (out_o_ack) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_i_ack    <= 1'b1;
            column_i_ack <= 1'b1;
            out          <= 32'd0;
            out_o_stb    <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            len_q        <= '0;
            idx          <= '0;
            acc          <= 32'd0;
            prod         <= 32'd0;
            mul_a_stb    <= 1'b0;
            mul_b_stb    <= 1'b0;
            add_a_stb    <= 1'b0;
            add_b_stb    <= 1'b0;
            mul_z_ack    <= 1'b0;
            add_z_ack    <= 1'b0;
        end else begin
            row_i_ack    <= (state_d == IDLE);
            column_i_ack <= (state_d == IDLE);
            mul_z_ack    <= (state_q == MUL_WAIT) & mul_z_stb;
            add_z_ack    <= (state_q == ADD_WAIT) & add_z_stb;
            if (mul_a_stb & mul_a_ack) mul_a_stb <= 1'b0;
            if (mul_b_stb & mul_b_ack) mul_b_stb <= 1'b0;
            if (add_a_stb & add_a_ack) add_a_stb <= 1'b0;
            if (add_b_stb & add_b_ack) add_b_stb <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    row_q <= row;
                    col_q <= column;
                    len_q <= len_c;
                    idx   <= '0;
                    acc   <= acc_init;
                    if (len_c == '0) begin
                        out       <= acc_init;
                        out_o_stb <= 1'b1;
                    end else begin
                        mul_a_stb <= 1'b1;
                        mul_b_stb <= 1'b1;
                    end
                end
                MUL_WAIT: if (mul_z_stb) begin
                    prod      <= mul_z;
                    add_a_stb <= 1'b1;
                    add_b_stb <= 1'b1;
                end
                ADD_WAIT: if (add_z_stb) begin
                    acc <= add_z;
                    idx <= idx + LEN_W'(1);
                    if (last) begin
                        out       <= add_z;
                        out_o_stb <= 1'b1;
                    end else begin
                        mul_a_stb <= 1'b1;
                        mul_b_stb <= 1'b1;
                    end
                end
                DONE: if (out_o_ack) out_o_stb <= 1'b0;
                default: ;
            endcase
        end
    end

    fp_core #(.IS_ADD(1'b0)) u_multiplier (
        .clk(clk), .rst(rst),
        .input_a(mul_a), .input_a_stb(mul_a_stb), .input_a_ack(mul_a_ack),
        .input_b(mul_b), .input_b_stb(mul_b_stb), .input_b_ack(mul_b_ack),
        .output_z(mul_z), .output_z_stb(mul_z_stb), .output_z_ack(mul_z_ack)
    );

    fp_core #(.IS_ADD(1'b1)) u_adder (
        .clk(clk), .rst(rst),
        .input_a(acc), .input_a_stb(add_a_stb), .input_a_ack(add_a_ack),
        .input_b(prod), .input_b_stb(add_b_stb), .input_b_ack(add_b_ack),
        .output_z(add_z), .output_z_stb(add_z_stb), .output_z_ack(add_z_ack)
    );
endmodule

// File: tb/tb_inner_product_seq.sv
// tb/tb_inner_product_seq.sv - directed vector bench for inner_product_seq
module tb_inner_product_seq;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] row = '0;
    logic [127:0] column = '0;
    logic [2:0]   len = '0;
    logic         acc_mode = 1'b0;
    logic         row_i_stb = 1'b0;
    logic         column_i_stb = 1'b0;
    logic         row_i_ack, column_i_ack, out_o_stb, busy;
    logic [31:0]  out;
    logic         out_o_ack = 1'b0;

    inner_product_seq #(.N(N)) dut (
        .clk(clk), .rst(rst), .row(row), .column(column), .len(len), .acc_mode(acc_mode),
        .row_i_stb(row_i_stb), .column_i_stb(column_i_stb),
        .row_i_ack(row_i_ack), .column_i_ack(column_i_ack),
        .out(out), .out_o_stb(out_o_stb), .out_o_ack(out_o_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int mul_stb_cycles = 0;

    always @(posedge clk) if (dut.mul_a_stb) mul_stb_cycles++;

    typedef struct {
        string        name;
        logic [127:0] row;
        logic [127:0] col;
        logic [2:0]   len;
        logic         acc_mode;
        logic [31:0]  exp;
    } vec_t;

    localparam logic [127:0] R_1234 = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    localparam logic [127:0] C_ONES = {4{32'h3F800000}};
    localparam logic [127:0] C_5678 = {32'h41000000, 32'h40E00000, 32'h40C00000, 32'h40A00000};
    localparam logic [127:0] R_NEG  = {32'h0, 32'h0, 32'hC0400000, 32'h40000000};
    localparam logic [127:0] C_NEG  = {32'h0, 32'h0, 32'h3F000000, 32'h3FC00000};
    localparam logic [127:0] R_M15  = {32'h0, 32'h0, 32'h0, 32'hBFC00000};
    localparam logic [127:0] C_25   = {32'h0, 32'h0, 32'h0, 32'h40200000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_out(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (out_o_stb) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_out_stb_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic start(input logic [127:0] r, input logic [127:0] c, input logic [2:0] l,
                         input logic am);
        row = r;
        column = c;
        len = l;
        acc_mode = am;
        row_i_stb = 1'b1;
        column_i_stb = 1'b1;
        @(negedge clk);
        row_i_stb = 1'b0;
        column_i_stb = 1'b0;
        row = '1;
        column = '1;
        len = 3'd1;
        acc_mode = ~am;
    endtask

    task automatic finish_out(input string name);
        out_o_ack = 1'b1;
        @(negedge clk);
        out_o_ack = 1'b0;
        check({name, "_stb_drop"}, {31'd0, out_o_stb}, 32'd0);
        check({name, "_idle_ack"}, {30'd0, row_i_ack, column_i_ack}, 32'd3);
    endtask

    vec_t vecs[8];
    int   stb_before;
    bit   held_ok;
    logic [31:0] snap;

    initial begin
        vecs[0] = '{"ones",     R_1234, C_ONES, 3'd4, 1'b0, 32'h41200000};
        vecs[1] = '{"dot70",    R_1234, C_5678, 3'd4, 1'b0, 32'h428C0000};
        vecs[2] = '{"chain140", R_1234, C_5678, 3'd4, 1'b1, 32'h430C0000};
        vecs[3] = '{"len7",     R_1234, C_5678, 3'd7, 1'b0, 32'h428C0000};
        vecs[4] = '{"len0_acc", R_1234, C_5678, 3'd0, 1'b1, 32'h428C0000};
        vecs[5] = '{"len0",     R_1234, C_5678, 3'd0, 1'b0, 32'h00000000};
        vecs[6] = '{"len2",     R_1234, C_5678, 3'd2, 1'b0, 32'h41880000};
        vecs[7] = '{"mixsign",  R_NEG,  C_NEG,  3'd2, 1'b0, 32'h3FC00000};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_out", out, 32'd0);
        check("reset_stb_busy", {30'd0, out_o_stb, busy}, 32'd0);
        check("reset_acks", {30'd0, row_i_ack, column_i_ack}, 32'd3);

        // stray output ack while idle must be harmless
        out_o_ack = 1'b1;
        @(negedge clk);
        out_o_ack = 1'b0;

        foreach (vecs[i]) begin
            stb_before = mul_stb_cycles;
            start(vecs[i].row, vecs[i].col, vecs[i].len, vecs[i].acc_mode);
            check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
            wait_out(vecs[i].name);
            check({vecs[i].name, "_out"}, out, vecs[i].exp);
            if (vecs[i].len == 3'd0)
                check({vecs[i].name, "_no_mul"}, mul_stb_cycles - stb_before, 32'd0);
            finish_out(vecs[i].name);
        end

        start(R_M15, C_25, 3'd1, 1'b0);
        wait_out("neg1");
        check("neg1_out", out, 32'hC0700000);
        finish_out("neg1");

        // single stb never accepted
        row = R_1234;
        column = C_5678;
        len = 3'd4;
        acc_mode = 1'b0;
        row_i_stb = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!(row_i_ack && column_i_ack && !busy)) held_ok = 1'b0;
        end
        check("single_stb_idle", {31'd0, held_ok}, 32'd1);
        column_i_stb = 1'b1;
        @(negedge clk);
        row_i_stb = 1'b0;
        column_i_stb = 1'b0;
        check("late_col_accept", {31'd0, busy}, 32'd1);
        check("late_col_ack_low", {30'd0, row_i_ack, column_i_ack}, 32'd0);
        wait_out("late_col");
        check("late_col_out", out, 32'h428C0000);

        // consumer stalls: result must stay put
        held_ok = 1'b1;
        snap = out;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(out_o_stb && out === snap)) held_ok = 1'b0;
        end
        check("stall_hold", {31'd0, held_ok}, 32'd1);
        row_i_stb = 1'b1;
        column_i_stb = 1'b1;
        row = R_1234;
        column = C_ONES;
        out_o_ack = 1'b1;
        @(negedge clk);
        out_o_ack = 1'b0;
        check("stall_release_stb", {31'd0, out_o_stb}, 32'd0);
        check("stall_release_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        row_i_stb = 1'b0;
        column_i_stb = 1'b0;
        check("queued_accept_busy", {31'd0, busy}, 32'd1);
        wait_out("queued");
        check("queued_out", out, 32'h41200000);
        finish_out("queued");
        repeat (5) @(negedge clk);
        check("out_holds_idle", out, 32'h41200000);

        // reset during ADD_WAIT
        start(R_1234, C_5678, 3'd4, 1'b0);
        held_ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (dut.add_a_ack) begin
                held_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("add_ack_seen", {31'd0, held_ok}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out", out, 32'd0);
        check("midrst_flags", {28'd0, out_o_stb, busy, row_i_ack, column_i_ack}, 32'd3);
        start(R_1234, C_5678, 3'd4, 1'b1);
        wait_out("post_rst");
        check("post_rst_out", out, 32'h428C0000);
        finish_out("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
